xil_ctrl_regbank: RTL
=====================

// Module: xil_ctrl_regbank
// PURPOSE
//  Parametrised control/status register bank on the Xillybus-style addressed memory port.
//  Generalises the 8-bit x 32 user memory to DATA_W x 2**ADDR_W, with:
//   - a read-only ID word and read-only status inputs;
//   - write-1-to-pulse strobes;
//   - a soft-reset sequencer triggered by a magic write, so RESET is a real FSM, not a stored byte.
//  Sits between the Xillybus core (bus_clk domain) and the DAQ datapath control nets.
// PARAMETERS
//  ADDR_W     5      address width; bank depth = 2**ADDR_W words
//  DATA_W     8      word width, must be >= 8
//  N_RO       4      status words at top addresses 2**ADDR_W-N_RO .. 2**ADDR_W-1, 1 <= N_RO <= 2**ADDR_W-3
//  ID_VALUE   8'hA5  constant returned at address 0, zero-extended to DATA_W
//  RST_ADDR   1      soft-reset command/status address
//  RST_MAGIC  8'h0F  value that starts soft reset, zero-extended to DATA_W
//  RST_LEN    16     soft_rst high time in cycles, >= 1
//  HOLD_LEN   8      post-reset holdoff in cycles, >= 0
//  PULSE_ADDR 2      write-1-to-pulse address
// PORTS
//  bus_clk          in   1                 single clock, all logic
//  rst_b            in   1                 asynchronous, active-low reset
//  user_w_mem_wren  in   1                 write strobe, 1 cycle per write
//  user_r_mem_rden  in   1                 read strobe
//  user_mem_addr    in   ADDR_W            shared read/write address
//  user_w_mem_data  in   DATA_W            write data
//  user_r_mem_data  out  DATA_W            registered read data
//  status_in        in   N_RO*DATA_W       status words; word k maps to address 2**ADDR_W-N_RO+k
//  ctrl_out         out  2**ADDR_W*DATA_W  word a = RW register a; non-RW slots drive 0
//  pulse_out        out  DATA_W            1-cycle strobes
//  soft_rst         out  1                 active-high soft reset to the datapath
//  soft_rst_busy    out  1                 high in ASSERT and HOLDOFF
// BEHAVIOUR
//  Reset (rst_b=0, async): RW regs, user_r_mem_data, pulse_out, drop_cnt = 0.
//   soft_rst=0, soft_rst_busy=0, FSM=IDLE. Release is synchronous to bus_clk.
//  Address classes:
//   0           ID, read-only
//   RST_ADDR    command/status
//   PULSE_ADDR  write-1-to-pulse
//   top N_RO    status, read-only
//   all other   RW
//  Writes (wren=1 at edge):
//   RW address: register updates at that edge.
//   PULSE_ADDR: pulse_out = data for exactly the next cycle, then 0. Back-to-back writes give back-to-back pulses.
//   RST_ADDR, data==RST_MAGIC, FSM IDLE: go to ASSERT. Any other data is ignored.
//   ID and status addresses: writes ignored.
//  Reads: rden=1 at edge N -> user_r_mem_data valid from edge N, held until the next rden.
//   Values returned:
//    ID          ID_VALUE
//    RST_ADDR    {soft_rst_busy, drop_cnt[DATA_W-2:0]}
//    PULSE_ADDR  0
//    status      status_in sampled at edge N
//    RW          register value
//  Same-edge wren+rden to one address: read returns the pre-write value.
//  FSM:
//   IDLE -> ASSERT on magic write.
//   ASSERT: soft_rst=1 for exactly RST_LEN cycles; on entry all RW regs clear to 0.
//   ASSERT -> HOLDOFF (soft_rst=0) for HOLD_LEN cycles, then -> IDLE. HOLD_LEN=0 goes straight to IDLE.
//   soft_rst_busy = (state != IDLE); registered, so it rises 1 cycle after the magic write.
//  While busy:
//   Magic writes ignored (no restart).
//   RW and pulse writes dropped; each increments drop_cnt, saturating at all-ones.
//   Reads always served.
//   drop_cnt clears only on rst_b or on the next accepted magic write.
//  rst_b asserted mid-sequence: FSM returns to IDLE immediately, soft_rst drops asynchronously.
//  Address wrap: none needed; every ADDR_W value decodes to exactly one class.
// TESTING
//  1. Reset, then read addr 0 -> 8'hA5 one cycle after rden; all ctrl_out = 0.
//  2. Write 0x01..0x09 to addrs 3..11, read back -> identical values; write to status addr 31 -> ignored, reads status_in[31 slot].
//  3. Write 8'h0F to addr 1 -> busy rises next cycle, soft_rst high 16 cycles, busy low after 24 cycles; RW regs read 0.
//  4. During ASSERT: write addr 3 three times and magic twice -> addr1 reads {1,7'd3}, no restart; next magic clears count.
//  5. Write 8'h81 to addr 2 -> pulse_out=8'h81 for 1 cycle; addr 2 reads 0; same-edge wr/rd on addr 5 returns old value.
//  6. Drop rst_b at cycle 5 of ASSERT -> soft_rst=0 immediately; after release FSM IDLE, next magic runs a full 16-cycle sequence.

Source files
------------

// File: rtl/xil_ctrl_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : xil_ctrl_regbank
//  Purpose  : Control/status register bank on a Xillybus-style memory port,
//             with ID/status words, write-1 pulses and a soft-reset sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module xil_ctrl_regbank #(
    parameter int         ADDR_W     = 5,
    parameter int         DATA_W     = 8,
    parameter int         N_RO       = 4,
    parameter logic [7:0] ID_VALUE   = 8'hA5,
    parameter int         RST_ADDR   = 1,
    parameter logic [7:0] RST_MAGIC  = 8'h0F,
    parameter int         RST_LEN    = 16,
    parameter int         HOLD_LEN   = 8,
    parameter int         PULSE_ADDR = 2
) (
    input  logic                             bus_clk,
    input  logic                             rst_b,
    input  logic                             user_w_mem_wren,
    input  logic                             user_r_mem_rden,
    input  logic [ADDR_W-1:0]                user_mem_addr,
    input  logic [DATA_W-1:0]                user_w_mem_data,
    output logic [DATA_W-1:0]                user_r_mem_data,
    input  logic [N_RO*DATA_W-1:0]           status_in,
    output logic [(2**ADDR_W)*DATA_W-1:0]    ctrl_out,
    output logic [DATA_W-1:0]                pulse_out,
    output logic                             soft_rst,
    output logic                             soft_rst_busy
);

    localparam int c_depth     = 2**ADDR_W;
    localparam int c_stat_base = c_depth - N_RO;
    localparam int c_cnt_max   = (RST_LEN > HOLD_LEN) ? RST_LEN : HOLD_LEN;
    localparam int c_cnt_w     = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_rst_load  = c_cnt_w'(RST_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [DATA_W-2:0]  c_drop_one  = (DATA_W-1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    function automatic logic is_rw_addr(input int a);
        return (a != 0) && (a != RST_ADDR) && (a != PULSE_ADDR) && (a < c_stat_base);
    endfunction

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [c_cnt_w-1:0]              r_cnt;
    logic [c_cnt_w-1:0]              w_cnt_nxt;
    logic                            r_soft_rst;
    logic                            r_busy;
    logic [DATA_W-2:0]               r_drop_cnt;
    logic [DATA_W-1:0]               r_rd_data;
    logic [DATA_W-1:0]               r_pulse;
    logic [DATA_W-1:0]               w_rd_val;
    logic [c_depth-1:0][DATA_W-1:0]  w_word;

    logic w_is_id, w_is_rst, w_is_pulse, w_is_stat, w_is_rw;
    logic w_idle, w_magic, w_rw_wr, w_pulse_wr, w_drop;

    // Address classes are mutually exclusive; RW is whatever is left over.
    assign w_is_id    = (user_mem_addr == '0);
    assign w_is_rst   = (user_mem_addr == ADDR_W'(RST_ADDR));
    assign w_is_pulse = (user_mem_addr == ADDR_W'(PULSE_ADDR));
    assign w_is_stat  = (user_mem_addr >= ADDR_W'(c_stat_base));
    assign w_is_rw    = !(w_is_id || w_is_rst || w_is_pulse || w_is_stat);

    assign w_idle     = (r_state == S_IDLE);
    assign w_magic    = user_w_mem_wren && w_is_rst && w_idle &&
                        (user_w_mem_data == DATA_W'(RST_MAGIC));
    assign w_rw_wr    = user_w_mem_wren && w_is_rw && w_idle;
    assign w_pulse_wr = user_w_mem_wren && w_is_pulse && w_idle;
    assign w_drop     = user_w_mem_wren && (w_is_rw || w_is_pulse) && !w_idle;

    generate
        for (genvar a = 0; a < c_depth; a++) begin : g_word
            if (is_rw_addr(a)) begin : g_rw
                logic [DATA_W-1:0] r_reg;
                always_ff @(posedge bus_clk or negedge rst_b) begin
                    if (!rst_b) begin
                        r_reg <= '0;
                    end else if (w_magic) begin
                        r_reg <= '0;
                    end else if (w_rw_wr && (user_mem_addr == ADDR_W'(a))) begin
                        r_reg <= user_w_mem_data;
                    end
                end
                assign w_word[a] = r_reg;
            end else begin : g_ro
                assign w_word[a] = '0;
            end
        end
    endgenerate

    always_ff @(posedge bus_clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_soft_rst <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_soft_rst <= (w_state_nxt == S_ASSERT);
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    // r_cnt holds the remaining cycles in the current phase, minus one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_magic) begin
                    w_state_nxt = S_ASSERT;
                    w_cnt_nxt   = c_rst_load;
                end
            end
            S_ASSERT: begin
                if (r_cnt == '0) begin
                    if (HOLD_LEN == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = c_hold_load;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge bus_clk or negedge rst_b) begin
        if (!rst_b) begin
            r_drop_cnt <= '0;
        end else if (w_magic) begin
            r_drop_cnt <= '0;
        end else if (w_drop && !(&r_drop_cnt)) begin
            r_drop_cnt <= r_drop_cnt + c_drop_one;
        end
    end

    always_ff @(posedge bus_clk or negedge rst_b) begin
        if (!rst_b) begin
            r_pulse <= '0;
        end else if (w_pulse_wr) begin
            r_pulse <= user_w_mem_data;
        end else begin
            r_pulse <= '0;
        end
    end

    always_comb begin
        w_rd_val = '0;
        if (w_is_id) begin
            w_rd_val = DATA_W'(ID_VALUE);
        end else if (w_is_rst) begin
            w_rd_val = {r_busy, r_drop_cnt};
        end else if (w_is_pulse) begin
            w_rd_val = '0;
        end else if (w_is_stat) begin
            for (int k = 0; k < N_RO; k++) begin
                if (user_mem_addr == ADDR_W'(c_stat_base + k)) begin
                    w_rd_val = status_in[k*DATA_W +: DATA_W];
                end
            end
        end else begin
            w_rd_val = w_word[user_mem_addr];
        end
    end

    // Read data reflects pre-edge state, so a same-edge write is not visible.
    always_ff @(posedge bus_clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rd_data <= '0;
        end else if (user_r_mem_rden) begin
            r_rd_data <= w_rd_val;
        end
    end

    assign user_r_mem_data = r_rd_data;
    assign ctrl_out        = w_word;
    assign pulse_out       = r_pulse;
    assign soft_rst        = r_soft_rst;
    assign soft_rst_busy   = r_busy;

endmodule
`default_nettype wire
